byte_serializer: RTL

//  Parallel-to-serial stage feeding the serial bit-to-byte deserializer. Accepts

---
 rtl/byte_serializer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - MSB-first word serializer with one-entry hold register and flush line.
// Optional build macro SER_PARITY_EN appends an even parity bit to every frame.
module byte_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             flush_out,
  output logic             byte_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             bit_q, bit_n;
  logic             flush_q, flush_n;
  logic             done_q, done_n;
  logic             take;
  logic             load;
  logic [WIDTH-1:0] load_word;
`ifdef SER_PARITY_EN
  logic             par_q, par_n;
`endif

  assign data_ready = ~hold_full;
  assign busy       = (state == SHIFT) | hold_full;
  assign bit_out    = bit_q;
  assign flush_out  = flush_q;
  assign byte_done  = done_q;

  always_comb begin
    state_n     = state;
    sh_n        = sh;
    hold_n      = hold;
    hold_full_n = hold_full;
    cnt_n       = cnt;
    bit_n       = bit_q;
    flush_n     = flush_q;
    load        = 1'b0;
    load_word   = data_in;
    take        = data_valid & ~hold_full;
`ifdef SER_PARITY_EN
    par_n       = par_q;
`endif
    case (state)
      IDLE: begin
        if (take) load = 1'b1;
      end
      SHIFT: begin
        if (cnt != LAST_CNT) begin
          sh_n  = sh << 1;
          cnt_n = cnt + CW'(1);
          bit_n = sh[WIDTH-2];
`ifdef SER_PARITY_EN
          if (cnt == CW'(WIDTH - 1)) bit_n = par_q;
`endif
          if (take) begin
            hold_n      = data_in;
            hold_full_n = 1'b1;
          end
        end else if (hold_full) begin
          load        = 1'b1;
          load_word   = hold;
          hold_full_n = 1'b0;
        end else if (take) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
          flush_n = 1'b1;
          bit_n   = 1'b0;
          sh_n    = '0;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // Loading a new word (from IDLE or chained at the last-bit edge) restarts the frame.
    if (load) begin
      state_n = SHIFT;
      sh_n    = load_word;
      bit_n   = load_word[WIDTH-1];
      cnt_n   = '0;
      flush_n = 1'b0;
`ifdef SER_PARITY_EN
      par_n   = ^load_word;
`endif
    end
    done_n = (state_n == SHIFT) && (cnt_n == LAST_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      bit_q     <= 1'b0;
      flush_q   <= 1'b1;
      done_q    <= 1'b0;
`ifdef SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      cnt       <= cnt_n;
      bit_q     <= bit_n;
      flush_q   <= flush_n;
      done_q    <= done_n;
`ifdef SER_PARITY_EN
      par_q     <= par_n;
`endif
    end
  end

endmodule
